// File: rtl/seq_det_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {IDLE, SEARCH, HIT} det_state_t;

    localparam int unsigned PAT_W_MIN = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky flag raised when the count reaches all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         sat
);

    logic [W-1:0] count_d;
    logic         sat_d;

    always_comb begin
        count_d = count;
        sat_d   = sat;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else begin
            if (inc && (count != {W{1'b1}})) begin
                count_d = count + W'(1);
            end
            sat_d = sat | (count_d == {W{1'b1}});
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= count_d;
            sat   <= sat_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with Mealy/Moore outputs,
// selectable overlap and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap_in,
    input  logic             clear,
    input  logic             din_valid,
    input  logic             din,
    output logic             armed,
    output logic             dout_mealy,
    output logic             dout_moore,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    det_state_t       state_q, state_d;
    logic [PAT_W-1:0] pattern_q;
    logic             overlap_q;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] window;
    logic             accept;
    logic             match;

    // cfg_load and clear both suppress the bit presented in their cycle.
    assign accept = din_valid && (state_q != IDLE) && !cfg_load && !clear;
    assign window = {hist_q[PAT_W-2:0], din};
    assign match  = accept && (fill_q >= FILL_W'(PAT_W - 1)) && (window == pattern_q);

    assign armed      = (state_q != IDLE);
    assign dout_mealy = match;
    assign dout_moore = (state_q == HIT);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        if (cfg_load) begin
            state_d = SEARCH;
            hist_d  = '0;
            fill_d  = '0;
        end else if (clear) begin
            state_d = (state_q == IDLE) ? IDLE : SEARCH;
            hist_d  = '0;
            fill_d  = '0;
        end else begin
            if (state_q != IDLE) begin
                state_d = match ? HIT : SEARCH;
            end
            if (match && !overlap_q) begin
                hist_d = '0;
                fill_d = '0;
            end else if (accept) begin
                hist_d = window;
                if (fill_q != FILL_W'(PAT_W)) begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            overlap_q <= 1'b0;
            hist_q    <= '0;
            fill_q    <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            if (cfg_load) begin
                pattern_q <= pattern_in;
                overlap_q <= overlap_in;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (match),
        .clr  (cfg_load | clear),
        .count(match_count),
        .sat  (count_sat)
    );

endmodule
